// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the multiport register file.
//   state_t      - scrub controller states (IDLE, CLEAR)
//   reg_addr_t   - default-width register index (5 bits)
//   reg_data_t   - default-width register data (32 bits)
//   REG_ZERO_IDX - index of the hardwired-zero register x0
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] reg_data_t;

   localparam int REG_ZERO_IDX = 0;

endpackage : regfile_pkg

// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if: bus between decode/writeback (master) and the
// register file (slave).
//   we, waddr, wdata - single synchronous write port
//   raddr / rdata    - READ_PORTS packed read ports, port i at slice i
//   a0               - mirror of register A0_INDEX
//   busy             - scrub in progress, writes are dropped
interface regfile_multiport_if #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int READ_PORTS    = 2
);

   logic                               we;
   logic [ADDRESS_WIDTH-1:0]           waddr;
   logic [DATA_WIDTH-1:0]              wdata;
   logic [READ_PORTS*ADDRESS_WIDTH-1:0] raddr;
   logic [READ_PORTS*DATA_WIDTH-1:0]    rdata;
   logic [DATA_WIDTH-1:0]              a0;
   logic                               busy;

   modport master (
      output we, waddr, wdata, raddr,
      input  rdata, a0, busy
   );

   modport slave (
      input  we, waddr, wdata, raddr,
      output rdata, a0, busy
   );

endinterface : regfile_multiport_if

// File: rtl/regfile_scrub_ctrl.sv
// regfile_scrub_ctrl: reset-triggered scrub engine for the register file.
// After reset is released it walks scrub_idx from 0 to depth-1, asserting
// scrub_we each cycle so the top level writes zero to that entry.
//   clk, rst   - clock and synchronous active-high reset
//   busy       - high while scrubbing and while rst is held
//   scrub_we   - write-zero strobe for entry scrub_idx
//   scrub_idx  - entry being cleared this cycle
module regfile_scrub_ctrl
   import regfile_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     busy,
   output logic                     scrub_we,
   output logic [ADDRESS_WIDTH-1:0] scrub_idx
);

   localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = {ADDRESS_WIDTH{1'b1}};

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] idx_q, idx_d;

   // State register; reset restarts the scrub from entry 0 even mid-scrub.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         CLEAR: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs. busy also covers the reset cycles themselves so a write
   // coinciding with rst is discarded; no entry is cleared while rst is held.
   always_comb begin
      busy     = rst || (state_q == CLEAR);
      scrub_we = !rst && (state_q == CLEAR);
   end

   assign scrub_idx = idx_q;

endmodule : regfile_scrub_ctrl

// File: rtl/regfile_multiport.sv
// regfile_multiport: RISC-V integer register file with READ_PORTS
// combinational read ports, one synchronous write port and x0 hardwired to 0.
// A scrub engine clears every entry after reset; busy blocks port writes.
//   clk, rst - clock and synchronous active-high reset
//   bus      - regfile_multiport_if.slave (we/waddr/wdata, raddr/rdata, a0, busy)
// Optional: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int READ_PORTS    = 2,
   parameter int A0_INDEX      = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_multiport_if.slave   bus
);

   localparam int                       DEPTH    = 2 ** ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(REG_ZERO_IDX);
   localparam logic [ADDRESS_WIDTH-1:0] A0_IDX   = ADDRESS_WIDTH'(A0_INDEX);

   logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
   logic                     busy;
   logic                     scrub_we;
   logic [ADDRESS_WIDTH-1:0] scrub_idx;
   logic                     port_we;

   regfile_scrub_ctrl #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) u_scrub (
      .clk       (clk),
      .rst       (rst),
      .busy      (busy),
      .scrub_we  (scrub_we),
      .scrub_idx (scrub_idx)
   );

   // Port writes are dropped (not queued) while busy; x0 writes are dropped.
   always_comb begin
      port_we = bus.we && !busy && (bus.waddr != ZERO_IDX);
   end

   // Storage: the scrub and the write port never overlap because busy
   // gates the port, so the mux priority only matters for clarity.
   always_ff @(posedge clk) begin
      if (scrub_we) begin
         mem_q[scrub_idx] <= '0;
      end else if (port_we) begin
         mem_q[bus.waddr] <= bus.wdata;
      end
   end

   assign bus.busy = busy;
   assign bus.a0   = mem_q[A0_IDX];

   for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_read
      logic [ADDRESS_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0]    rd;

      assign ra = bus.raddr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];

      always_comb begin
         rd = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
         // port_we already excludes busy and x0, matching the forwarding rule.
         if (port_we && (ra == bus.waddr)) begin
            rd = bus.wdata;
         end
`endif
         // x0 reads zero regardless of what the scrub left in entry 0.
         if (ra == ZERO_IDX) begin
            rd = '0;
         end
      end

      assign bus.rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
   end

endmodule : regfile_multiport
